// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the IF -> ID -> MEM -> WB pipeline
// sequencing controller.
//   - pc_state_e : controller FSM states (PC_RUN, PC_WAIT)
//   - fwd_sel_e  : operand forwarding selects (FWD_RF, FWD_MEM, FWD_WB)
//   - ctl_t      : bundle of enable / flush / bubble controls for the PC and
//                  the three intermediate registers
//   - run_ctl()  : control bundle for a cycle in which the pipe is free to
//                  move (branch, hazard or plain advance)
// Optional feature macro used by the files importing this package:
//   PIPE_FORWARD_EN
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

   localparam int REG_AW_DEF = 4;

   typedef enum logic [0:0] {
      PC_RUN  = 1'b0,
      PC_WAIT = 1'b1
   } pc_state_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_MEM = 2'b01,
      FWD_WB  = 2'b10
   } fwd_sel_e;

   typedef struct packed {
      logic pc_en;
      logic r1_en;
      logic r1_flush;
      logic r2_en;
      logic r2_bubble;
      logic r3_en;
      logic r3_bubble;
   } ctl_t;

   // Everything frozen: used while the data memory is busy.
   localparam ctl_t CTL_FREEZE = '{pc_en: 1'b0, r1_en: 1'b0, r1_flush: 1'b0,
                                   r2_en: 1'b0, r2_bubble: 1'b0,
                                   r3_en: 1'b0, r3_bubble: 1'b0};

   // While in reset every register loads a NOP so the pipe refills cleanly.
   localparam ctl_t CTL_RESET  = '{pc_en: 1'b0, r1_en: 1'b0, r1_flush: 1'b1,
                                   r2_en: 1'b0, r2_bubble: 1'b1,
                                   r3_en: 1'b0, r3_bubble: 1'b1};

   // Controls for a cycle where memory is not holding the pipe.
   // A taken branch wins over a hazard: the instructions that would have
   // stalled are squashed anyway.
   function automatic ctl_t run_ctl(input logic br_taken, input logic raw);
      ctl_t c;
      c = '{pc_en: 1'b1, r1_en: 1'b1, r1_flush: 1'b0,
            r2_en: 1'b1, r2_bubble: 1'b0,
            r3_en: 1'b1, r3_bubble: 1'b0};
      if (br_taken) begin
         c.r1_flush  = 1'b1;
         c.r2_bubble = 1'b1;
      end else if (raw) begin
         // Hold PC and IF/ID, inject a bubble into ID/MEM, let older work drain.
         c.pc_en     = 1'b0;
         c.r1_en     = 1'b0;
         c.r2_bubble = 1'b1;
      end
      return c;
   endfunction

endpackage

// File: rtl/pipe_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipe_hazard_unit
// Purely combinational RAW hazard detector and forwarding-select generator.
// Ports:
//   id_rs1/id_rs1_used, id_rs2/id_rs2_used : ID-stage source operands
//   mem_rd/mem_we/mem_is_load             : MEM-stage destination
//   wb_rd/wb_we                           : WB-stage destination
//   raw                                   : ID instruction must stall
//   fwd_a/fwd_b (PIPE_FORWARD_EN only)    : operand source selects
// Macro PIPE_FORWARD_EN: with forwarding only a load in MEM stalls; without
// it any in-flight write to a source register stalls.
// -----------------------------------------------------------------------------
module pipe_hazard_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] id_rs1,
   input  logic              id_rs1_used,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_we,
   input  logic              mem_is_load,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_we,
   output logic              raw
`ifdef PIPE_FORWARD_EN
   ,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b
`endif
);

   // Register 0 is hard-wired, so it never matches anything in flight.
   logic mem_hit1, mem_hit2, wb_hit1, wb_hit2;

   always_comb begin
      mem_hit1 = (id_rs1 != '0) && mem_we && (id_rs1 == mem_rd);
      mem_hit2 = (id_rs2 != '0) && mem_we && (id_rs2 == mem_rd);
      wb_hit1  = (id_rs1 != '0) && wb_we  && (id_rs1 == wb_rd);
      wb_hit2  = (id_rs2 != '0) && wb_we  && (id_rs2 == wb_rd);
   end

`ifdef PIPE_FORWARD_EN
   // A load result only exists after MEM, so it is the one case forwarding
   // cannot cover.
   assign raw = (id_rs1_used && mem_hit1 && mem_is_load) ||
                (id_rs2_used && mem_hit2 && mem_is_load);

   // MEM holds the younger write, so it takes priority over WB.
   always_comb begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      if (mem_hit1 && !mem_is_load) fwd_a = FWD_MEM;
      else if (wb_hit1)             fwd_a = FWD_WB;
      if (mem_hit2 && !mem_is_load) fwd_b = FWD_MEM;
      else if (wb_hit2)             fwd_b = FWD_WB;
   end
`else
   assign raw = (id_rs1_used && (mem_hit1 || wb_hit1)) ||
                (id_rs2_used && (mem_hit2 || wb_hit2));

   // Load-ness only matters when forwarding is built in.
   logic unused_is_load;
   assign unused_is_load = mem_is_load;
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline sequencing controller for the IF -> ID -> MEM -> WB core. Drives
// the PC enable and the enable / flush / bubble controls of IF/ID (r1),
// ID/MEM (r2) and MEM/WB (r3); stalls on RAW hazards, flushes on a taken
// branch, freezes during multi-cycle memory accesses and aborts a memory
// access that never acknowledges.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   id_*, mem_rd/we/is_load,
//   wb_rd/we                   : operand / destination info for hazards
//   br_taken                   : branch resolved taken in MEM
//   mem_req, mem_ack           : data memory handshake
//   pc_en, r1_*, r2_*, r3_*    : combinational pipeline controls
//   mem_err                    : one-cycle registered pulse on timeout
//   stall_cnt                  : saturating count of cycles with pc_en = 0
//   fwd_a, fwd_b               : forwarding selects (PIPE_FORWARD_EN only)
// Macro PIPE_FORWARD_EN enables operand forwarding.
// MEM_TIMEOUT must be at least 2.
// -----------------------------------------------------------------------------
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW      = REG_AW_DEF,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic              id_rs1_used,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_we,
   input  logic              mem_is_load,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_we,
   input  logic              br_taken,
   input  logic              mem_req,
   input  logic              mem_ack,
   output logic              pc_en,
   output logic              r1_en,
   output logic              r1_flush,
   output logic              r2_en,
   output logic              r2_bubble,
   output logic              r3_en,
   output logic              r3_bubble,
   output logic              mem_err,
   output logic [CNT_W-1:0]  stall_cnt
`ifdef PIPE_FORWARD_EN
   ,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b
`endif
);

   // The timer counts WAIT cycles from 0. The freezing RUN cycle is the
   // first frozen cycle, so the last one before abort sees MEM_TIMEOUT-2.
   localparam int               TMR_W    = $clog2(MEM_TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 2);

   pc_state_e        state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             raw;
   ctl_t             ctl;

   pipe_hazard_unit #(.REG_AW(REG_AW)) u_hazard (
      .id_rs1      (id_rs1),
      .id_rs1_used (id_rs1_used),
      .id_rs2      (id_rs2),
      .id_rs2_used (id_rs2_used),
      .mem_rd      (mem_rd),
      .mem_we      (mem_we),
      .mem_is_load (mem_is_load),
      .wb_rd       (wb_rd),
      .wb_we       (wb_we),
      .raw         (raw)
`ifdef PIPE_FORWARD_EN
      ,
      .fwd_a       (fwd_a),
      .fwd_b       (fwd_b)
`endif
   );

   // NOTE: every variable gets a default at the top of the block so no path
   // leaves it unassigned; that is what keeps this logic free of latches.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      mem_err_d = 1'b0;
      ctl       = CTL_FREEZE;

      if (!rst_n) begin
         ctl = CTL_RESET;
      end else begin
         case (state_q)
            PC_RUN: begin
               if (mem_req && !mem_ack) begin
                  state_d = PC_WAIT;
                  timer_d = '0;
               end else begin
                  ctl = run_ctl(br_taken, raw);
               end
            end
            PC_WAIT: begin
               // Releasing in the ack cycle itself costs no extra bubble.
               if (mem_ack) begin
                  ctl     = run_ctl(br_taken, raw);
                  state_d = PC_RUN;
                  timer_d = '0;
               end else if (timer_q == TMR_LAST) begin
                  // Abort: let the pipe move but drop the missing load data.
                  ctl           = run_ctl(br_taken, raw);
                  ctl.r3_bubble = 1'b1;
                  mem_err_d     = 1'b1;
                  state_d       = PC_RUN;
                  timer_d       = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
         endcase
      end

      stall_cnt_d = stall_cnt_q;
      if (!ctl.pc_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= PC_RUN;
         timer_q     <= '0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign pc_en     = ctl.pc_en;
   assign r1_en     = ctl.r1_en;
   assign r1_flush  = ctl.r1_flush;
   assign r2_en     = ctl.r2_en;
   assign r2_bubble = ctl.r2_bubble;
   assign r3_en     = ctl.r3_en;
   assign r3_bubble = ctl.r3_bubble;
   assign mem_err   = mem_err_q;
   assign stall_cnt = stall_cnt_q;

endmodule
